// File: rtl/orpsoc_jtag_pkg.sv
// Shared definitions for the JTAG memory shell: TAP states, IR opcodes and
// the bit layout of the MEMACC data register.
package orpsoc_jtag_pkg;

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI,
    ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PA_DR, ST_EX2_DR, ST_UPD_DR,
    ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PA_IR, ST_EX2_IR, ST_UPD_IR
  } tap_state_e;

  localparam int IR_W     = 4;
  localparam int DR_ID_W  = 32;
  localparam int DR_MEM_W = 65;
  localparam int WE_BIT   = 64;
  localparam int ADDR_MSB = 63;
  localparam int ADDR_LSB = 32;

  localparam logic [IR_W-1:0] IR_IDCODE  = 4'h1;
  localparam logic [IR_W-1:0] IR_MEMACC  = 4'h8;
  localparam logic [IR_W-1:0] IR_BYPASS  = 4'hF;
  localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;

endpackage

// File: rtl/jtag_tap_sync.sv
// Oversampled JTAG front end: pad synchronisers, tck edge detect, the
// IEEE 1149.1 TAP controller and the instruction register.
module jtag_tap_sync
  import orpsoc_jtag_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_tck,
  input  logic            i_tms,
  input  logic            i_tdi,
  output logic            o_tck_fall,
  output logic            o_tdi,
  output logic            o_capture_dr,
  output logic            o_shift_dr,
  output logic            o_update_dr,
  output logic            o_shift_ir_st,
  output logic            o_shift_dr_st,
  output logic            o_ir_tdo,
  output logic [IR_W-1:0] o_instr
);

  logic [2:0]      r_tck_sync;
  logic [1:0]      r_tms_sync;
  logic [1:0]      r_tdi_sync;
  tap_state_e      r_state;
  tap_state_e      w_state_nxt;
  logic [IR_W-1:0] r_ir_sr;
  logic [IR_W-1:0] r_instr;
  logic            w_rise;
  logic            w_tms;

  // Pad synchronisers; the third tck flop is the edge-detect reference.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tck_sync <= 3'b000;
      r_tms_sync <= 2'b00;
      r_tdi_sync <= 2'b00;
    end else begin
      r_tck_sync <= {r_tck_sync[1:0], i_tck};
      r_tms_sync <= {r_tms_sync[0], i_tms};
      r_tdi_sync <= {r_tdi_sync[0], i_tdi};
    end
  end

  assign w_rise     = r_tck_sync[1] & ~r_tck_sync[2];
  assign o_tck_fall = ~r_tck_sync[1] & r_tck_sync[2];
  assign w_tms      = r_tms_sync[1];
  assign o_tdi      = r_tdi_sync[1];

  // TAP state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_TLR;
    else          r_state <= w_state_nxt;
  end

  // TAP next-state, evaluated only on a detected tck rise.
  always_comb begin
    w_state_nxt = r_state;
    if (w_rise) begin
      case (r_state)
        ST_TLR:    w_state_nxt = w_tms ? ST_TLR    : ST_RTI;
        ST_RTI:    w_state_nxt = w_tms ? ST_SEL_DR : ST_RTI;
        ST_SEL_DR: w_state_nxt = w_tms ? ST_SEL_IR : ST_CAP_DR;
        ST_CAP_DR: w_state_nxt = w_tms ? ST_EX1_DR : ST_SH_DR;
        ST_SH_DR:  w_state_nxt = w_tms ? ST_EX1_DR : ST_SH_DR;
        ST_EX1_DR: w_state_nxt = w_tms ? ST_UPD_DR : ST_PA_DR;
        ST_PA_DR:  w_state_nxt = w_tms ? ST_EX2_DR : ST_PA_DR;
        ST_EX2_DR: w_state_nxt = w_tms ? ST_UPD_DR : ST_SH_DR;
        ST_UPD_DR: w_state_nxt = w_tms ? ST_SEL_DR : ST_RTI;
        ST_SEL_IR: w_state_nxt = w_tms ? ST_TLR    : ST_CAP_IR;
        ST_CAP_IR: w_state_nxt = w_tms ? ST_EX1_IR : ST_SH_IR;
        ST_SH_IR:  w_state_nxt = w_tms ? ST_EX1_IR : ST_SH_IR;
        ST_EX1_IR: w_state_nxt = w_tms ? ST_UPD_IR : ST_PA_IR;
        ST_PA_IR:  w_state_nxt = w_tms ? ST_EX2_IR : ST_PA_IR;
        ST_EX2_IR: w_state_nxt = w_tms ? ST_UPD_IR : ST_SH_IR;
        ST_UPD_IR: w_state_nxt = w_tms ? ST_SEL_DR : ST_RTI;
        default:   w_state_nxt = ST_TLR;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // IR shift register, and the latched instruction (forced in Test-Logic-Reset).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ir_sr <= IR_CAPTURE;
      r_instr <= IR_IDCODE;
    end else begin
      if (w_rise && r_state == ST_CAP_IR)     r_ir_sr <= IR_CAPTURE;
      else if (w_rise && r_state == ST_SH_IR) r_ir_sr <= {o_tdi, r_ir_sr[IR_W-1:1]};
      if (r_state == ST_TLR)                              r_instr <= IR_IDCODE;
      else if (w_rise && w_state_nxt == ST_UPD_IR)        r_instr <= r_ir_sr;
    end
  end

  assign o_capture_dr  = w_rise && (r_state == ST_CAP_DR);
  assign o_shift_dr    = w_rise && (r_state == ST_SH_DR);
  assign o_update_dr   = w_rise && (w_state_nxt == ST_UPD_DR);
  assign o_shift_ir_st = (r_state == ST_SH_IR);
  assign o_shift_dr_st = (r_state == ST_SH_DR);
  assign o_ir_tdo      = r_ir_sr[0];
  assign o_instr       = r_instr;

endmodule

// File: rtl/orpsoc_jtag_mem_shell_mem.sv
// Memory wrapper; its ram0 instance holds the array the host preloads.
module orpsoc_jtag_mem_shell_mem #(
  parameter int unsigned WORDS = 32'd256,
  parameter int unsigned AW    = 32'd8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  orpsoc_jtag_mem_shell_ram #(.WORDS(WORDS), .AW(AW)) ram0 (
    .i_clk(i_clk), .i_we(i_we), .i_re(i_re),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata)
  );

endmodule

// File: rtl/orpsoc_jtag_mem_shell_ram.sv
// Word RAM with one synchronous write port and one registered read port;
// contents are deliberately not reset so a preloaded image survives reset.
module orpsoc_jtag_mem_shell_ram #(
  parameter int unsigned WORDS = 32'd256,
  parameter int unsigned AW    = 32'd8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [0:WORDS-1];

  // Write and read ports.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    if (i_re) o_rdata     <= mem[i_addr];
  end

endmodule

// File: rtl/orpsoc_jtag_mem_shell.sv
// SoC shell top: reset synchroniser, data registers behind the TAP, tdo and
// the on-chip RAM reached through the MEMACC instruction.
module orpsoc_jtag_mem_shell
  import orpsoc_jtag_pkg::*;
#(
  parameter logic [31:0] MEM_SIZE     = 32'h02000000,
  parameter logic [31:0] IDCODE_VALUE = 32'h14951185
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  input  logic tms_pad_i,
  input  logic tck_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o
);

  localparam logic [31:0] WORDS = MEM_SIZE >> 2;
  localparam int unsigned AW    = $clog2(WORDS);

  logic [1:0]          r_rst_sync;
  logic                wb_rst;
  logic                w_rst_n;
  logic                w_tck_fall, w_tdi;
  logic                w_capture_dr, w_shift_dr, w_update_dr;
  logic                w_shift_ir_st, w_shift_dr_st, w_ir_tdo;
  logic [IR_W-1:0]     w_instr;
  logic                w_sel_id, w_sel_mem;
  logic [DR_ID_W-1:0]  r_dr_id;
  logic                r_dr_byp;
  logic [DR_MEM_W-1:0] r_dr_mem;
  logic [31:0]         r_last_addr;
  logic [31:0]         r_rd_latch;
  logic                r_rd_pend;
  logic                r_tdo;
  logic                w_dr_bit0;
  logic                w_ram_we, w_ram_re;
  logic [AW-1:0]       w_ram_addr;
  logic [31:0]         w_ram_q;

  // Internal reset: asserts with the pad, releases two clocks later.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_rst_sync <= 2'b00;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign wb_rst  = ~r_rst_sync[1];
  assign w_rst_n = ~wb_rst;

  jtag_tap_sync u_tap (
    .i_clk(wb_clk_i), .i_rst_n(w_rst_n),
    .i_tck(tck_pad_i), .i_tms(tms_pad_i), .i_tdi(tdi_pad_i),
    .o_tck_fall(w_tck_fall), .o_tdi(w_tdi),
    .o_capture_dr(w_capture_dr), .o_shift_dr(w_shift_dr), .o_update_dr(w_update_dr),
    .o_shift_ir_st(w_shift_ir_st), .o_shift_dr_st(w_shift_dr_st),
    .o_ir_tdo(w_ir_tdo), .o_instr(w_instr)
  );

  // Every opcode other than IDCODE and MEMACC behaves as BYPASS.
  assign w_sel_id  = (w_instr == IR_IDCODE);
  assign w_sel_mem = (w_instr == IR_MEMACC);

  // Capture/shift of the selected data register, tdi entering at the MSB.
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_dr_id  <= 32'h0;
      r_dr_byp <= 1'b0;
      r_dr_mem <= 65'h0;
    end else if (w_capture_dr) begin
      if (w_sel_id)       r_dr_id  <= IDCODE_VALUE;
      else if (w_sel_mem) r_dr_mem <= {1'b0, r_last_addr, r_rd_latch};
      else                r_dr_byp <= 1'b0;
    end else if (w_shift_dr) begin
      if (w_sel_id)       r_dr_id  <= {w_tdi, r_dr_id[DR_ID_W-1:1]};
      else if (w_sel_mem) r_dr_mem <= {w_tdi, r_dr_mem[DR_MEM_W-1:1]};
      else                r_dr_byp <= w_tdi;
    end
  end

  assign w_ram_we   = w_update_dr && w_sel_mem && r_dr_mem[WE_BIT];
  assign w_ram_re   = w_update_dr && w_sel_mem && !r_dr_mem[WE_BIT];
  assign w_ram_addr = AW'((r_dr_mem[ADDR_MSB:ADDR_LSB] >> 2) % WORDS);

  // MEMACC update: latch the address; reads land in the latch a cycle later.
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_last_addr <= 32'h0;
      r_rd_latch  <= 32'h0;
      r_rd_pend   <= 1'b0;
    end else begin
      if (w_update_dr && w_sel_mem) r_last_addr <= r_dr_mem[ADDR_MSB:ADDR_LSB];
      r_rd_pend <= w_ram_re;
      if (r_rd_pend) r_rd_latch <= w_ram_q;
    end
  end

  orpsoc_jtag_mem_shell_mem #(.WORDS(WORDS), .AW(AW)) wb_bfm_memory0 (
    .i_clk(wb_clk_i), .i_we(w_ram_we), .i_re(w_ram_re),
    .i_addr(w_ram_addr), .i_wdata(r_dr_mem[31:0]), .o_rdata(w_ram_q)
  );

  // Bit 0 of whichever data register the current instruction selects.
  always_comb begin
    w_dr_bit0 = r_dr_byp;
    if (w_sel_id)       w_dr_bit0 = r_dr_id[0];
    else if (w_sel_mem) w_dr_bit0 = r_dr_mem[0];
    else                w_dr_bit0 = r_dr_byp;
  end

  // tdo changes only on tck falls in a shift state, otherwise holds.
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) r_tdo <= 1'b0;
    else if (w_tck_fall && w_shift_ir_st) r_tdo <= w_ir_tdo;
    else if (w_tck_fall && w_shift_dr_st) r_tdo <= w_dr_bit0;
  end

  assign tdo_pad_o = r_tdo;

endmodule

// File: tb/tb_orpsoc_jtag_mem_shell.sv
// Directed bench: a table of IR/DR scans with hand-computed tdo images plus
// backdoor memory checks and a reset-during-shift sequence.
module tb_orpsoc_jtag_mem_shell;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tms = 1'b1;
  logic tck = 1'b0;
  logic tdi = 1'b0;
  logic tdo;
  logic last_tdo = 1'b0;

  int errors = 0;
  int checks = 0;

  orpsoc_jtag_mem_shell #(.MEM_SIZE(32'h00000400), .IDCODE_VALUE(32'h14951185)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .tms_pad_i(tms),
    .tck_pad_i(tck), .tdi_pad_i(tdi), .tdo_pad_o(tdo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ld_ir;
    logic [3:0]  ir;
    int          width;
    logic [64:0] din;
    logic [64:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One tck period; tdo is sampled after the falling edge settles.
  task automatic tick(input logic t_ms, input logic t_di);
    @(negedge clk);
    tms = t_ms;
    tdi = t_di;
    repeat (5) @(posedge clk);
    tck = 1'b1;
    repeat (5) @(posedge clk);
    tck = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    last_tdo = tdo;
  endtask

  // From Run-Test-Idle through Shift-IR/Update-IR back to Run-Test-Idle.
  task automatic scan_ir(input logic [3:0] val, output logic [3:0] dout);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dout[i] = last_tdo;
      tick(i == 3, val[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int width, input logic [64:0] din, output logic [64:0] dout);
    dout = 65'h0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < width; i++) begin
      dout[i] = last_tdo;
      tick(i == width - 1, din[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  function automatic logic [64:0] macc(input logic we, input logic [31:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  logic [3:0]  ir_out;
  logic [64:0] dr_out;

  initial begin
    vecs[0]  = '{"idcode_after_reset", 1'b0, 4'h1, 32, 65'h0, 65'h14951185};
    vecs[1]  = '{"memacc_rd_c_first",  1'b1, 4'h8, 65, macc(1'b0, 32'hC, 32'h0), 65'h0};
    vecs[2]  = '{"memacc_rd_c_result", 1'b1, 4'h8, 65, macc(1'b0, 32'hC, 32'h0),
                 macc(1'b0, 32'hC, 32'hDEADBEEF)};
    vecs[3]  = '{"memacc_wr_10",       1'b1, 4'h8, 65, macc(1'b1, 32'h10, 32'h12345678),
                 macc(1'b0, 32'hC, 32'hDEADBEEF)};
    vecs[4]  = '{"latch_kept_on_wr",   1'b1, 4'h8, 65, macc(1'b0, 32'h10, 32'h0),
                 macc(1'b0, 32'h10, 32'hDEADBEEF)};
    vecs[5]  = '{"readback_10",        1'b1, 4'h8, 65, macc(1'b0, 32'h404, 32'h0),
                 macc(1'b0, 32'h10, 32'h12345678)};
    vecs[6]  = '{"wrap_404_mem1",      1'b1, 4'h8, 65, macc(1'b0, 32'h13, 32'h0),
                 macc(1'b0, 32'h404, 32'hCAFEF00D)};
    vecs[7]  = '{"unaligned_13_mem4",  1'b1, 4'h8, 65, macc(1'b0, 32'h0, 32'h0),
                 macc(1'b0, 32'h13, 32'h12345678)};
    vecs[8]  = '{"bypass_f",           1'b1, 4'hF, 9, 65'h0A5, 65'h14A};
    vecs[9]  = '{"bypass_unused_5",    1'b1, 4'h5, 9, 65'h0A5, 65'h14A};
    vecs[10] = '{"idcode_reload",      1'b1, 4'h1, 32, 65'h0, 65'h14951185};

    dut.wb_bfm_memory0.ram0.mem[3] = 32'hDEADBEEF;
    dut.wb_bfm_memory0.ram0.mem[1] = 32'hCAFEF00D;
    dut.wb_bfm_memory0.ram0.mem[4] = 32'h0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("tdo_in_reset", {64'h0, tdo}, 65'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].ld_ir) begin
        scan_ir(vecs[v].ir, ir_out);
        chk({vecs[v].name, "_ir_capture"}, {61'h0, ir_out}, 65'h1);
      end
      scan_dr(vecs[v].width, vecs[v].din, dr_out);
      chk(vecs[v].name, dr_out, vecs[v].exp);
      if (v == 3)
        chk("mem4_after_write", {33'h0, dut.wb_bfm_memory0.ram0.mem[4]}, 65'h12345678);
    end

    // Write whose result is checked as soon as the Update-DR tck completes.
    scan_ir(4'h8, ir_out);
    scan_dr(65, macc(1'b1, 32'h14, 32'h0BADCAFE), dr_out);
    chk("mem5_write", {33'h0, dut.wb_bfm_memory0.ram0.mem[5]}, 65'h0BADCAFE);

    // Reset in the middle of a BYPASS shift of ones.
    scan_ir(4'hF, ir_out);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("tdo_before_midreset", {64'h0, last_tdo}, 65'h1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("tdo_midreset", {64'h0, tdo}, 65'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    tick(1'b0, 1'b0);
    scan_dr(32, 65'h0, dr_out);
    chk("idcode_after_midreset", dr_out, 65'h14951185);
    chk("mem3_preserved", {33'h0, dut.wb_bfm_memory0.ram0.mem[3]}, 65'hDEADBEEF);
    chk("mem4_preserved", {33'h0, dut.wb_bfm_memory0.ram0.mem[4]}, 65'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
